// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing defaults and coordinate type for the
// timing generator and every downstream pixel renderer.
package vga_pkg;

   localparam int unsigned COORD_W        = 10;

   localparam int unsigned DEF_H_VISIBLE  = 640;
   localparam int unsigned DEF_H_FP       = 16;
   localparam int unsigned DEF_H_SYNC     = 96;
   localparam int unsigned DEF_H_BP       = 48;
   localparam int unsigned DEF_H_TOTAL    = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

   localparam int unsigned DEF_V_VISIBLE  = 480;
   localparam int unsigned DEF_V_FP       = 10;
   localparam int unsigned DEF_V_SYNC     = 2;
   localparam int unsigned DEF_V_BP       = 33;
   localparam int unsigned DEF_V_TOTAL    = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   // Sync windows are [START, START+SYNC) in counter coordinates.
   localparam int unsigned DEF_HS_START   = DEF_H_VISIBLE + DEF_H_FP;
   localparam int unsigned DEF_HS_END     = DEF_HS_START + DEF_H_SYNC;
   localparam int unsigned DEF_VS_START   = DEF_V_VISIBLE + DEF_V_FP;
   localparam int unsigned DEF_VS_END     = DEF_VS_START + DEF_V_SYNC;

   localparam int unsigned DEF_SYNC_DELAY = 1;

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } run_state_e;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register used to delay-match hsync/vsync to the
// renderers' registered colour output. DEPTH=0 is a plain wire.
module sync_delay_line
   import vga_pkg::*;
#(
   parameter int unsigned     WIDTH     = 2,
   parameter int unsigned     DEPTH     = DEF_SYNC_DELAY,
   parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign dout           = din;
   end else begin : g_pipe
      logic [DEPTH-1:0][WIDTH-1:0] stage_q;
      logic [DEPTH-1:0][WIDTH-1:0] stage_d;

      always_comb begin
         stage_d    = stage_q;
         stage_d[0] = din;
         for (int i = 1; i < int'(DEPTH); i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end

      // NOTE: every stage is preset, so the connector sees inactive (high)
      // syncs from the moment reset asserts, not DEPTH clocks later.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            stage_q <= {DEPTH{RESET_VAL}};
         end else begin
            stage_q <= stage_d;
         end
      end

      assign dout = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: registered scan position, drawable flag, frame
// strobes and delay-matched active-low syncs.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
   parameter int unsigned H_FP       = DEF_H_FP,
   parameter int unsigned H_SYNC     = DEF_H_SYNC,
   parameter int unsigned H_BP       = DEF_H_BP,
   parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
   parameter int unsigned V_FP       = DEF_V_FP,
   parameter int unsigned V_SYNC     = DEF_V_SYNC,
   parameter int unsigned V_BP       = DEF_V_BP,
   parameter int unsigned SYNC_DELAY = DEF_SYNC_DELAY
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start,
   output logic       vblank_start
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
   localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
   localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FP);
   localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FP);
   localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

   if (H_TOTAL > 1024) begin : g_bad_h_total
      $error("vga_timing_gen: H_TOTAL %0d does not fit a 10-bit counter", H_TOTAL);
   end
   if (V_TOTAL > 1024) begin : g_bad_v_total
      $error("vga_timing_gen: V_TOTAL %0d does not fit a 10-bit counter", V_TOTAL);
   end
   if (SYNC_DELAY > 4) begin : g_bad_delay
      $error("vga_timing_gen: SYNC_DELAY %0d exceeds 4", SYNC_DELAY);
   end

   run_state_e state_q, state_d;
   coord_t     x_q, x_d;
   coord_t     y_q, y_d;
   logic       blank_q, blank_d;
   logic       frame_start_q, frame_start_d;
   logic       vblank_start_q, vblank_start_d;
   logic       hsync_raw_q, hsync_raw_d;
   logic       vsync_raw_q, vsync_raw_d;
   logic [1:0] sync_dly;

   // IDLE holds the raster at (0,0) for the first edge after reset release,
   // so that edge presents pixel (0,0) with frame_start instead of (1,0).
   // NOTE: every signal gets a default before any branch so no latch is inferred.
   always_comb begin
      state_d = ST_RUN;
      x_d     = x_q;
      y_d     = y_q;

      if (state_q == ST_RUN) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
      end

      // Decode from the next position so flags line up with DrawX/DrawY.
      blank_d        = (x_d < H_VIS) && (y_d < V_VIS);
      frame_start_d  = (x_d == '0) && (y_d == '0);
      vblank_start_d = (x_d == '0) && (y_d == V_VIS);
      hsync_raw_d    = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
      vsync_raw_d    = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         x_q            <= '0;
         y_q            <= '0;
         blank_q        <= 1'b0;
         frame_start_q  <= 1'b0;
         vblank_start_q <= 1'b0;
         hsync_raw_q    <= 1'b1;
         vsync_raw_q    <= 1'b1;
      end else begin
         state_q        <= state_d;
         x_q            <= x_d;
         y_q            <= y_d;
         blank_q        <= blank_d;
         frame_start_q  <= frame_start_d;
         vblank_start_q <= vblank_start_d;
         hsync_raw_q    <= hsync_raw_d;
         vsync_raw_q    <= vsync_raw_d;
      end
   end

   sync_delay_line #(
      .WIDTH     (2),
      .DEPTH     (SYNC_DELAY),
      .RESET_VAL (2'b11)
   ) u_sync_delay (
      .clk   (vga_clk),
      .rst_n (reset_n),
      .din   ({hsync_raw_q, vsync_raw_q}),
      .dout  (sync_dly)
   );

   assign DrawX        = x_q;
   assign DrawY        = y_q;
   assign blank        = blank_q;
   assign frame_start  = frame_start_q;
   assign vblank_start = vblank_start_q;
   assign hsync        = sync_dly[1];
   assign vsync        = sync_dly[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default raster at sync delays 1/0/3 plus a small raster
// (15x8 clocks) for frame-level behaviour and a three-frame scoreboard.
module tb_vga_timing_gen;

   logic vga_clk = 1'b0;
   logic reset_n = 1'b0;

   always #20 vga_clk = ~vga_clk;

   logic [9:0] x1, y1, x0, y0, x3, y3, xs, ys;
   logic       b1, b0, b3, bs;
   logic       hs1, hs0, hs3, hss;
   logic       vs1, vs0, vs3, vss;
   logic       fs1, fs0, fs3, fss;
   logic       vb1, vb0, vb3, vbs;

   vga_timing_gen u_d1 (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(x1), .DrawY(y1), .blank(b1),
      .hsync(hs1), .vsync(vs1), .frame_start(fs1), .vblank_start(vb1)
   );

   vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(x0), .DrawY(y0), .blank(b0),
      .hsync(hs0), .vsync(vs0), .frame_start(fs0), .vblank_start(vb0)
   );

   vga_timing_gen #(.SYNC_DELAY(3)) u_d3 (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(x3), .DrawY(y3), .blank(b3),
      .hsync(hs3), .vsync(vs3), .frame_start(fs3), .vblank_start(vb3)
   );

   // Small raster: H 8+2+3+2=15, V 4+1+2+1=8, frame = 120 clocks.
   vga_timing_gen #(
      .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(1)
   ) u_sm (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(xs), .DrawY(ys), .blank(bs),
      .hsync(hss), .vsync(vss), .frame_start(fss), .vblank_start(vbs)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;
   int t         = 0;   // edges since the first post-reset edge
   int sb_blank [3];
   int sb_fs    [3];
   int sb_vb    [3];
   int line0_blank = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, obs, exp, t);
   endtask

   task automatic accumulate();
      if (t < 360) begin
         if (bs  === 1'b1) sb_blank[t/120]++;
         if (fss === 1'b1) sb_fs[t/120]++;
         if (vbs === 1'b1) sb_vb[t/120]++;
      end
      if (t < 800 && b1 === 1'b1) line0_blank++;
   endtask

   task automatic goto(input int target);
      while (t < target) begin
         @(negedge vga_clk);
         t++;
         accumulate();
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         sb_blank[i] = 0; sb_fs[i] = 0; sb_vb[i] = 0;
      end

      // Held in reset across several edges.
      repeat (3) @(negedge vga_clk);
      check("rst_x",     x1,  0);
      check("rst_y",     y1,  0);
      check("rst_blank", b1,  0);
      check("rst_fs",    fs1, 0);
      check("rst_vb",    vb1, 0);
      check("rst_hs1",   hs1, 1);
      check("rst_vs1",   vs1, 1);
      check("rst_hs0",   hs0, 1);
      check("rst_hs3",   hs3, 1);
      check("rst_vs3",   vs3, 1);

      reset_n = 1'b1;
      @(negedge vga_clk);
      t = 0;
      accumulate();
      check("first_x",     x1,  0);
      check("first_y",     y1,  0);
      check("first_blank", b1,  1);
      check("first_fs",    fs1, 1);
      check("first_hs",    hs1, 1);
      check("first_vs",    vs1, 1);
      check("first_fs_sm", fss, 1);

      for (int i = 1; i < 10; i++) begin
         goto(i);
         check($sformatf("run_x%0d", i), x1, i);
         check("run_y",     y1,  0);
         check("run_blank", b1,  1);
         check("run_fs",    fs1, 0);
         check("run_hs",    hs1, 1);
      end

      // Small raster: hsync raw low x 10..12, seen one clock later.
      goto(10);  check("sm_hs_10", hss, 1);
      goto(11);  check("sm_hs_11", hss, 0);
      goto(13);  check("sm_hs_13", hss, 0);
      goto(14);  check("sm_hs_14", hss, 1);
                 check("sm_x_14",  xs,  14);
                 check("sm_y_14",  ys,  0);
      goto(15);  check("sm_xwrap", xs,  0);
                 check("sm_yinc",  ys,  1);
                 check("sm_blank_15", bs, 1);
      goto(59);  check("sm_vb_59", vbs, 0);
                 check("sm_x_59",  xs,  14);
                 check("sm_y_59",  ys,  3);
      goto(60);  check("sm_vb_60", vbs, 1);
                 check("sm_y_60",  ys,  4);
                 check("sm_blank_60", bs, 0);
      goto(61);  check("sm_vb_61", vbs, 0);
      // vsync raw low for lines 5..6 (t 75..104), output one clock later.
      goto(75);  check("sm_vs_75",  vss, 1);
      goto(76);  check("sm_vs_76",  vss, 0);
      goto(105); check("sm_vs_105", vss, 0);
      goto(106); check("sm_vs_106", vss, 1);
      goto(119); check("sm_x_119",  xs,  14);
                 check("sm_y_119",  ys,  7);
                 check("sm_fs_119", fss, 0);
      goto(120); check("sm_fwrap_x", xs, 0);
                 check("sm_fwrap_y", ys, 0);
                 check("sm_fs_120",  fss, 1);
                 check("sm_blank_120", bs, 1);

      goto(360);
      for (int f = 0; f < 3; f++) begin
         check($sformatf("sb_blank_f%0d", f), sb_blank[f], 32);
         check($sformatf("sb_fs_f%0d", f),    sb_fs[f],    1);
         check($sformatf("sb_vb_f%0d", f),    sb_vb[f],    1);
      end

      // Default raster, line 0.
      goto(639); check("x_639",     x1, 639);
                 check("blank_639", b1, 1);
      goto(640); check("blank_640", b1, 0);
      goto(655); check("hs0_655", hs0, 1);
                 check("hs1_655", hs1, 1);
      goto(656); check("hs0_656", hs0, 0);
                 check("hs1_656", hs1, 1);
      goto(657); check("hs1_657", hs1, 0);
      goto(658); check("hs3_658", hs3, 1);
      goto(659); check("hs3_659", hs3, 0);
      goto(751); check("hs0_751", hs0, 0);
                 check("hs1_751", hs1, 0);
      goto(752); check("hs0_752", hs0, 1);
                 check("hs1_752", hs1, 0);
                 check("hs3_752", hs3, 0);
      goto(753); check("hs1_753", hs1, 1);
      goto(754); check("hs3_754", hs3, 0);
      goto(755); check("hs3_755", hs3, 1);
      goto(799); check("x1_799", x1, 799);
                 check("y1_799", y1, 0);
                 check("x0_799", x0, 799);
                 check("x3_799", x3, 799);
      goto(800); check("x1_wrap", x1, 0);
                 check("y1_inc",  y1, 1);
                 check("y0_inc",  y0, 1);
                 check("y3_inc",  y3, 1);
                 check("blank_800", b1, 1);
                 check("vs1_800", vs1, 1);
      check("line0_blank_count", line0_blank, 640);

      // Mid-frame async reset: default at (670,1) in hsync, small at (0,2) drawable.
      goto(1470);
      check("pre_x1",  x1,  670);
      check("pre_hs1", hs1, 0);
      check("pre_hs0", hs0, 0);
      check("pre_hs3", hs3, 0);
      check("pre_bs",  bs,  1);
      check("pre_ys",  ys,  2);
      #5 reset_n = 1'b0;
      #1;
      check("async_x1",  x1,  0);
      check("async_y1",  y1,  0);
      check("async_hs1", hs1, 1);
      check("async_hs0", hs0, 1);
      check("async_hs3", hs3, 1);
      check("async_bs",  bs,  0);
      check("async_ys",  ys,  0);
      repeat (2) @(negedge vga_clk);
      check("hold_x1",  x1,  0);
      check("hold_b1",  b1,  0);
      check("hold_fs1", fs1, 0);
      reset_n = 1'b1;
      @(negedge vga_clk);
      check("rel_x1",  x1,  0);
      check("rel_y1",  y1,  0);
      check("rel_b1",  b1,  1);
      check("rel_fs1", fs1, 1);
      check("rel_fss", fss, 1);
      @(negedge vga_clk);
      check("rel_x1_next",  x1,  1);
      check("rel_fs1_next", fs1, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
